// File: rtl/idma_nd_unroller.sv
`default_nettype none
// ============================================================================
// Module   : idma_nd_unroller
// Brief    : Unrolls one 3-D ND transfer into a stream of 1-D backend requests.
//            Dim 0 is the contiguous length; dims 1 and 2 carry rep counts and
//            independent src/dst strides. One request per handshake, done pulse
//            in the cycle after the last request is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module idma_nd_unroller #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned LenWidth  = 32,
  parameter int unsigned RepWidth  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   nd_valid_i,
  output logic                   nd_ready_o,
  input  logic [AddrWidth-1:0]   nd_src_addr_i,
  input  logic [AddrWidth-1:0]   nd_dst_addr_i,
  input  logic [LenWidth-1:0]    nd_length_i,
  input  logic [2*RepWidth-1:0]  nd_reps_i,
  input  logic [2*AddrWidth-1:0] nd_src_stride_i,
  input  logic [2*AddrWidth-1:0] nd_dst_stride_i,
  output logic                   req_valid_o,
  input  logic                   req_ready_i,
  output logic [AddrWidth-1:0]   req_src_addr_o,
  output logic [AddrWidth-1:0]   req_dst_addr_o,
  output logic [LenWidth-1:0]    req_length_o,
  output logic                   req_last_o,
  output logic                   nd_done_o,
  output logic                   busy_o
);

  localparam logic [RepWidth-1:0] c_rep_one  = {{(RepWidth-1){1'b0}}, 1'b1};
  localparam logic [RepWidth-1:0] c_rep_zero = '0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  state_e r_state;
  state_e w_state_next;

  // Job context captured at accept time
  logic [AddrWidth-1:0] r_s1, r_s2, r_d1, r_d2;
  logic [RepWidth-1:0]  r_r1, r_r2;
  logic [LenWidth-1:0]  r_len;

  // Walking pointers: dim-2 (outer) and dim-1 (inner, the emitted address)
  logic [AddrWidth-1:0] r_src1, r_dst1, r_src2, r_dst2;
  logic [RepWidth-1:0]  r_c1, r_c2;
  logic                 r_done;

  logic                 w_hs;
  logic                 w_c1_end;
  logic                 w_last;
  logic                 w_accept;
  logic [RepWidth-1:0]  w_r1_in, w_r2_in;
  logic [AddrWidth-1:0] w_src2_nxt, w_dst2_nxt;

  assign w_accept   = (r_state == ST_IDLE) && nd_valid_i;
  assign w_hs       = (r_state == ST_EMIT) && req_ready_i;
  assign w_c1_end   = (r_c1 == (r_r1 - c_rep_one));
  assign w_last     = (r_state == ST_EMIT) && w_c1_end && (r_c2 == (r_r2 - c_rep_one));

  // A zero rep count means "one repetition" so every job emits at least one request
  assign w_r1_in    = (nd_reps_i[RepWidth-1:0] == c_rep_zero) ? c_rep_one
                                                              : nd_reps_i[RepWidth-1:0];
  assign w_r2_in    = (nd_reps_i[2*RepWidth-1:RepWidth] == c_rep_zero) ? c_rep_one
                                                                       : nd_reps_i[2*RepWidth-1:RepWidth];

  assign w_src2_nxt = r_src2 + r_s2;
  assign w_dst2_nxt = r_dst2 + r_d2;

  assign nd_ready_o     = (r_state == ST_IDLE);
  assign busy_o         = (r_state == ST_EMIT);
  assign req_valid_o    = (r_state == ST_EMIT);
  assign req_src_addr_o = r_src1;
  assign req_dst_addr_o = r_dst1;
  assign req_length_o   = r_len;
  assign req_last_o     = w_last;
  assign nd_done_o      = r_done;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state: leave IDLE on accept, return once the last request is taken
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (nd_valid_i)     w_state_next = ST_EMIT;
      ST_EMIT: if (w_hs && w_last) w_state_next = ST_IDLE;
      default:                     w_state_next = ST_IDLE;
    endcase
  end

  // Job capture and pointer/counter advance on each non-final handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_d1   <= '0;
      r_d2   <= '0;
      r_r1   <= '0;
      r_r2   <= '0;
      r_len  <= '0;
      r_src1 <= '0;
      r_dst1 <= '0;
      r_src2 <= '0;
      r_dst2 <= '0;
      r_c1   <= '0;
      r_c2   <= '0;
    end else if (w_accept) begin
      r_s1   <= nd_src_stride_i[AddrWidth-1:0];
      r_s2   <= nd_src_stride_i[2*AddrWidth-1:AddrWidth];
      r_d1   <= nd_dst_stride_i[AddrWidth-1:0];
      r_d2   <= nd_dst_stride_i[2*AddrWidth-1:AddrWidth];
      r_r1   <= w_r1_in;
      r_r2   <= w_r2_in;
      r_len  <= nd_length_i;
      r_src1 <= nd_src_addr_i;
      r_dst1 <= nd_dst_addr_i;
      r_src2 <= nd_src_addr_i;
      r_dst2 <= nd_dst_addr_i;
      r_c1   <= '0;
      r_c2   <= '0;
    end else if (w_hs && !w_last) begin
      if (!w_c1_end) begin
        r_c1   <= r_c1 + c_rep_one;
        r_src1 <= r_src1 + r_s1;
        r_dst1 <= r_dst1 + r_d1;
      end else begin
        // Inner dim exhausted: step the outer pointer and restart inner from it
        r_c1   <= '0;
        r_c2   <= r_c2 + c_rep_one;
        r_src2 <= w_src2_nxt;
        r_dst2 <= w_dst2_nxt;
        r_src1 <= w_src2_nxt;
        r_dst1 <= w_dst2_nxt;
      end
    end
  end

  // Done pulse one cycle after the final handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) r_done <= 1'b0;
    else       r_done <= w_hs && w_last;
  end

endmodule
`default_nettype wire
